// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the parametrised SPI slave front-end.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4,
        DONE      = 3'd5
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // A frame is two command bits followed by the payload.
    function automatic int frame_w(input int dataW);
        return dataW + 2;
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load serialiser that drives the read-back byte onto MISO, MSB first.
module spi_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              miso_o
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              miso_q, miso_d;

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == '0);
    assign miso_o = miso_q;

    // Clear wins over load; once the LSB has had its cycle, MISO drops back to 0.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        miso_d  = miso_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            miso_d  = 1'b0;
        end else if (load_i) begin
            miso_d  = data_i[DATA_W-1];
            shift_d = data_i[DATA_W-2:0];
            cnt_d   = CNT_W'(DATA_W - 1);
            busy_d  = 1'b1;
        end else if (done_o) begin
            miso_d  = 1'b0;
            busy_d  = 1'b0;
        end else if (busy_q) begin
            miso_d  = shift_q[DATA_W-2];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - 1'b1;
        end
    end

    // Shifter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            miso_q  <= miso_d;
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end: frames MOSI into {cmd, payload} words and serialises read-back data.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        SS_n_i,
    input  logic                        MOSI_i,
    input  logic [DATA_W-1:0]           tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        MISO_o,
    output logic [frame_w(DATA_W)-1:0]  rx_data_o,
    output logic                        rx_valid_o,
    output logic                        frame_err_o
);

    localparam int FRAME_W = frame_w(DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bitCnt_q, bitCnt_d;
    logic [FRAME_W-1:0]   rxData_q, rxData_d;
    logic                 rxValid_q, rxValid_d;
    logic                 frameErr_q, frameErr_d;
    logic                 rdAddrDone_q, rdAddrDone_d;
    logic                 txPhase_q, txPhase_d;
    logic                 txLoad, txClear, txBusy, txDone;

    spi_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (txLoad),
        .clear_i (txClear),
        .data_i  (tx_data_i),
        .busy_o  (txBusy),
        .done_o  (txDone),
        .miso_o  (MISO_o)
    );

    assign rx_data_o   = rxData_q;
    assign rx_valid_o  = rxValid_q;
    assign frame_err_o = frameErr_q;

    // Next-state logic: SS_n high aborts any active frame; a read that has just finished its last bit counts as complete.
    always_comb begin
        state_d      = state_q;
        bitCnt_d     = bitCnt_q;
        rxData_d     = rxData_q;
        rxValid_d    = 1'b0;
        frameErr_d   = 1'b0;
        rdAddrDone_d = rdAddrDone_q;
        txPhase_d    = txPhase_q;
        txLoad       = 1'b0;
        txClear      = 1'b0;
        if ((state_q != IDLE) && SS_n_i) begin
            state_d   = IDLE;
            bitCnt_d  = '0;
            txPhase_d = 1'b0;
            txClear   = 1'b1;
            if ((state_q == READ_DATA) && txDone) begin
                rdAddrDone_d = 1'b0;
            end else if (state_q != DONE) begin
                frameErr_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    bitCnt_d  = '0;
                    txPhase_d = 1'b0;
                    if (!SS_n_i) begin
                        state_d = CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    rxData_d[FRAME_W-1] = MOSI_i;
                    bitCnt_d            = CNT_W'(FRAME_W - 2);
                    if (!MOSI_i) begin
                        state_d = WRITE;
                    end else if (rdAddrDone_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!txPhase_q) begin
                        rxData_d[bitCnt_q] = MOSI_i;
                        if (bitCnt_q == '0) begin
                            rxValid_d = 1'b1;
                            if (state_q == READ_DATA) begin
                                txPhase_d = 1'b1;
                            end else begin
                                state_d = DONE;
                                if (state_q == READ_ADD) begin
                                    rdAddrDone_d = 1'b1;
                                end
                            end
                        end else begin
                            bitCnt_d = bitCnt_q - 1'b1;
                        end
                    end else if (txDone) begin
                        rdAddrDone_d = 1'b0;
                        txPhase_d    = 1'b0;
                        state_d      = DONE;
                    end else if (!txBusy && tx_valid_i) begin
                        txLoad = 1'b1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM and receive-path registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bitCnt_q     <= '0;
            rxData_q     <= '0;
            rxValid_q    <= 1'b0;
            frameErr_q   <= 1'b0;
            rdAddrDone_q <= 1'b0;
            txPhase_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitCnt_q     <= bitCnt_d;
            rxData_q     <= rxData_d;
            rxValid_q    <= rxValid_d;
            frameErr_q   <= frameErr_d;
            rdAddrDone_q <= rdAddrDone_d;
            txPhase_q    <= txPhase_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param: directed frame table, randomised frames, reset and 16-bit cases.
module tb_spi_slave_param;
    import spi_slave_pkg::*;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] payload;
        int         abortBits;
        int         txDelay;
        logic [7:0] txByte;
        int         abortMiso;
        int         extra;
        bit         isReadData;
        bit         expValid;
        logic [9:0] expRxData;
        bit         expErr;
        int         expMisoBits;
    } frame_rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        MISO;
    logic [9:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;

    logic        SS16 = 1'b1;
    logic        MOSI16 = 1'b0;
    logic [15:0] tx_data16 = '0;
    logic        tx_valid16 = 1'b0;
    logic        MISO16;
    logic [17:0] rx_data16;
    logic        rx_valid16;
    logic        frame_err16;

    int testsRun = 0;
    int testsFailed = 0;

    int         obsTick, obsValidCount, obsValidTick, obsErrCount, obsStray;
    logic [9:0] obsRxData;
    logic [7:0] obsMiso;
    bit         mRdAddrDone = 1'b0;

    spi_slave_param #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SS_n_i      (SS_n),
        .MOSI_i      (MOSI),
        .tx_data_i   (tx_data),
        .tx_valid_i  (tx_valid),
        .MISO_o      (MISO),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .frame_err_o (frame_err)
    );

    spi_slave_param #(.DATA_W(16)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .SS_n_i      (SS16),
        .MOSI_i      (MOSI16),
        .tx_data_i   (tx_data16),
        .tx_valid_i  (tx_valid16),
        .MISO_o      (MISO16),
        .rx_data_o   (rx_data16),
        .rx_valid_o  (rx_valid16),
        .frame_err_o (frame_err16)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom);
    endfunction

    function automatic frame_rec_t mk(input logic [1:0] cmd, input logic [7:0] payload,
                                      input int abortBits, input int txDelay, input logic [7:0] txByte,
                                      input int abortMiso, input int extra, input bit isRd,
                                      input bit expValid, input logic [9:0] expRx, input bit expErr,
                                      input int expMisoBits);
        frame_rec_t r;
        r.cmd = cmd; r.payload = payload; r.abortBits = abortBits; r.txDelay = txDelay;
        r.txByte = txByte; r.abortMiso = abortMiso; r.extra = extra; r.isReadData = isRd;
        r.expValid = expValid; r.expRxData = expRx; r.expErr = expErr; r.expMisoBits = expMisoBits;
        return r;
    endfunction

    task automatic check(input string what, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", what, got, exp);
        end
    endtask

    // Transaction-level reference: decides what a frame should produce from the command rules alone.
    task automatic modelFrame(inout frame_rec_t r);
        bit full;
        full          = (r.abortBits >= 10);
        r.expRxData   = {r.cmd, r.payload};
        r.expValid    = full;
        r.isReadData  = full && r.cmd[1] && mRdAddrDone;
        r.expErr      = 1'b0;
        r.expMisoBits = 0;
        if (!full) begin
            r.expErr = 1'b1;
        end else if (r.cmd[1] && !mRdAddrDone) begin
            mRdAddrDone = 1'b1;
        end else if (r.isReadData) begin
            if (r.abortMiso < 0) begin
                r.expMisoBits = 8;
                mRdAddrDone   = 1'b0;
            end else begin
                r.expMisoBits = r.abortMiso;
                r.expErr      = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, let the rising edge happen, record outputs at the next falling edge.
    task automatic tick(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd, input bit window);
        SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
        @(posedge clk);
        @(negedge clk);
        obsTick++;
        if (rx_valid === 1'b1) begin
            obsValidCount++;
            obsValidTick = obsTick;
            obsRxData    = rx_data;
        end
        if (frame_err !== 1'b0) obsErrCount++;
        if (window) obsMiso = {obsMiso[6:0], MISO};
        else if (MISO !== 1'b0) obsStray++;
    endtask

    task automatic applyStimulus(input frame_rec_t r);
        logic [9:0] f;
        int n;
        f = {r.cmd, r.payload};
        obsTick = -1; obsValidCount = 0; obsValidTick = -1; obsErrCount = 0; obsStray = 0;
        obsRxData = '0; obsMiso = '0;
        tick(1'b0, rbit(), 1'b0, rbyte(), 1'b0);
        for (int i = 0; i < r.abortBits && i < 10; i++) tick(1'b0, f[9-i], rbit(), rbyte(), 1'b0);
        if (r.abortBits < 10) begin
            tick(1'b1, rbit(), 1'b0, rbyte(), 1'b0);
            return;
        end
        if (r.isReadData) begin
            for (int i = 0; i < r.txDelay; i++) tick(1'b0, rbit(), 1'b0, rbyte(), 1'b0);
            if (r.abortMiso == 0) begin
                tick(1'b1, rbit(), 1'b0, rbyte(), 1'b0);
                return;
            end
            n = (r.abortMiso < 0) ? 8 : r.abortMiso;
            tick(1'b0, rbit(), 1'b1, r.txByte, 1'b1);
            for (int i = 1; i < n; i++) tick(1'b0, rbit(), rbit(), rbyte(), 1'b1);
            if (r.abortMiso > 0) begin
                tick(1'b1, rbit(), 1'b0, rbyte(), 1'b0);
                return;
            end
            tick(1'b0, rbit(), rbit(), rbyte(), 1'b0);
        end
        for (int i = 0; i < r.extra; i++) tick(1'b0, rbit(), rbit(), rbyte(), 1'b0);
        tick(1'b1, rbit(), 1'b0, rbyte(), 1'b0);
    endtask

    task automatic checkOutput(input frame_rec_t r, input string name);
        logic [7:0] expMiso;
        expMiso = (r.expMisoBits == 0) ? 8'h00 : 8'(r.txByte >> (8 - r.expMisoBits));
        check({name, " rx_valid pulses"}, obsValidCount, r.expValid);
        if (r.expValid) begin
            check({name, " rx_valid edge"}, obsValidTick, 10);
            check({name, " rx_data"}, obsRxData, r.expRxData);
        end
        check({name, " frame_err pulses"}, obsErrCount, r.expErr);
        check({name, " miso bits"}, obsMiso, expMiso);
        check({name, " miso idle"}, obsStray, 0);
    endtask

    int v16Count, v16Tick, e16Count, s16Count, t16;
    logic [17:0] v16Data;

    task automatic tick16(input logic ss, input logic mosi);
        SS16 = ss; MOSI16 = mosi;
        @(posedge clk);
        @(negedge clk);
        t16++;
        if (rx_valid16 === 1'b1) begin
            v16Count++;
            v16Tick = t16;
            v16Data = rx_data16;
        end
        if (frame_err16 !== 1'b0) e16Count++;
        if (MISO16 !== 1'b0) s16Count++;
    endtask

    frame_rec_t vec[15];
    frame_rec_t r;
    logic [17:0] f16;

    initial begin
        vec[0]  = mk(CMD_WR_ADDR, 8'hA5, 10, 0, 8'h00, -1, 3, 0, 1, 10'h0A5, 0, 0);
        vec[1]  = mk(CMD_RD_ADDR, 8'h3C, 10, 0, 8'h00, -1, 1, 0, 1, 10'h23C, 0, 0);
        vec[2]  = mk(CMD_RD_DATA, 8'h00, 10, 2, 8'hC3, -1, 2, 1, 1, 10'h300, 0, 8);
        vec[3]  = mk(CMD_WR_DATA, 8'h5A, 5,  0, 8'h00, -1, 0, 0, 0, 10'h000, 1, 0);
        vec[4]  = mk(CMD_WR_DATA, 8'h5A, 10, 0, 8'h00, -1, 0, 0, 1, 10'h15A, 0, 0);
        vec[5]  = mk(CMD_RD_ADDR, 8'h77, 10, 0, 8'h00, -1, 0, 0, 1, 10'h277, 0, 0);
        vec[6]  = mk(CMD_RD_DATA, 8'h11, 10, 1, 8'hB6, 3,  0, 1, 1, 10'h311, 1, 3);
        vec[7]  = mk(CMD_RD_ADDR, 8'h42, 10, 0, 8'h5E, -1, 1, 1, 1, 10'h242, 0, 8);
        vec[8]  = mk(CMD_WR_ADDR, 8'h00, 0,  0, 8'h00, -1, 0, 0, 0, 10'h000, 1, 0);
        vec[9]  = mk(CMD_RD_DATA, 8'h00, 1,  0, 8'h00, -1, 0, 0, 0, 10'h000, 1, 0);
        vec[10] = mk(CMD_WR_ADDR, 8'hFF, 9,  0, 8'h00, -1, 0, 0, 0, 10'h000, 1, 0);
        vec[11] = mk(CMD_RD_DATA, 8'h01, 10, 0, 8'h00, -1, 0, 0, 1, 10'h301, 0, 0);
        vec[12] = mk(CMD_RD_ADDR, 8'h02, 10, 3, 8'h99, 0,  0, 1, 1, 10'h202, 1, 0);
        vec[13] = mk(CMD_WR_ADDR, 8'h80, 10, 0, 8'h00, -1, 2, 0, 1, 10'h080, 0, 0);
        vec[14] = mk(CMD_RD_DATA, 8'hFE, 10, 0, 8'h01, -1, 0, 1, 1, 10'h3FE, 0, 8);

        rst_n = 1'b0;
        tick(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        check("reset MISO", MISO, 0);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset frame_err", frame_err, 0);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 15; i++) begin
            r = vec[i];
            modelFrame(r);
            applyStimulus(vec[i]);
            checkOutput(vec[i], $sformatf("vec%0d", i));
        end

        r = mk(CMD_RD_ADDR, 8'h5C, 10, 0, 8'h00, -1, 0, 0, 0, 10'h000, 0, 0);
        modelFrame(r);
        applyStimulus(r);
        checkOutput(r, "pre-reset read address");
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0);
        check("mid reset MISO", MISO, 0);
        check("mid reset rx_data", rx_data, 0);
        check("mid reset rx_valid", rx_valid, 0);
        check("mid reset frame_err", frame_err, 0);
        rst_n = 1'b1;
        mRdAddrDone = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        r = mk(CMD_RD_DATA, 8'h6D, 10, 0, 8'h00, -1, 2, 0, 0, 10'h000, 0, 0);
        modelFrame(r);
        applyStimulus(r);
        checkOutput(r, "post-reset read");

        for (int k = 0; k < 40; k++) begin
            r.cmd       = 2'($urandom);
            r.payload   = rbyte();
            r.abortBits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10;
            r.txDelay   = int'($urandom_range(0, 3));
            r.txByte    = rbyte();
            r.abortMiso = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            r.extra     = int'($urandom_range(0, 3));
            modelFrame(r);
            applyStimulus(r);
            checkOutput(r, $sformatf("rand%0d", k));
        end

        f16 = {CMD_WR_DATA, 16'hBEEF};
        v16Count = 0; v16Tick = -1; e16Count = 0; s16Count = 0; t16 = -1; v16Data = '0;
        tick16(1'b0, 1'b0);
        for (int i = 0; i < 18; i++) tick16(1'b0, f16[17-i]);
        tick16(1'b0, 1'b1);
        tick16(1'b0, 1'b0);
        tick16(1'b1, 1'b0);
        check("w16 rx_valid pulses", v16Count, 1);
        check("w16 rx_valid edge", v16Tick, 18);
        check("w16 rx_data", v16Data, 18'h1BEEF);
        check("w16 frame_err pulses", e16Count, 0);
        check("w16 miso idle", s16Count, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
